kinase_valve_sequencer: RTL and testbench



---
 rtl/kinase_ctrl_pkg.sv | 24 ++
 rtl/kinase_pump_phase_gen.sv | 65 ++++++
 rtl/kinase_valve_sequencer.sv | 169 ++++++++++++++++
 tb/tb_kinase_valve_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kinase_ctrl_pkg.sv
// Shared types and pump phase tables for the kinase valve sequencer.
// Pad polarity: a 1 on any valve or pump line means actuated/closed.
package kinase_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PUMP,
    ST_DONE
  } state_e;

  localparam int NUM_PHASES = 6;
  localparam int PHASE_W    = 3;

  localparam logic [2:0] PUMP_A_REST = 3'b111;
  localparam logic [1:0] PUMP_B_REST = 2'b11;

  // Element [0] is the first phase of a forward stroke.
  localparam logic [NUM_PHASES-1:0][2:0] PUMP_A_PHASE =
    {3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};
  localparam logic [NUM_PHASES-1:0][1:0] PUMP_B_PHASE =
    {2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};

endpackage

// File: rtl/kinase_pump_phase_gen.sv
// Six-phase peristaltic sequencer: holds each phase PHASE_CYCLES cycles and
// flags the last cycle of every stroke. phase_o is the phase for the next cycle.
module kinase_pump_phase_gen
  import kinase_ctrl_pkg::*;
#(
  parameter int PHASE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               rev_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               stroke_end_o
);

  localparam int HOLD_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(PHASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PH_FIRST  = '0;
  localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(NUM_PHASES - 1);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] start_ph, end_ph;
  logic               phase_end;

  assign start_ph  = rev_i ? PH_LAST : PH_FIRST;
  assign end_ph    = rev_i ? PH_FIRST : PH_LAST;
  assign phase_end = (hold_q == HOLD_LAST);

  // While disabled the generator is parked on the first phase of a stroke,
  // so the first enabled cycle already shows the correct pattern.
  always_comb begin
    hold_d  = hold_q;
    phase_d = phase_q;
    if (!enable_i) begin
      hold_d  = '0;
      phase_d = start_ph;
    end else if (phase_end) begin
      hold_d = '0;
      if (phase_q == end_ph) begin
        phase_d = start_ph;
      end else if (rev_i) begin
        phase_d = phase_q - PHASE_W'(1);
      end else begin
        phase_d = phase_q + PHASE_W'(1);
      end
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= '0;
      phase_q <= '0;
    end else begin
      hold_q  <= hold_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o      = phase_d;
  assign stroke_end_o = enable_i && phase_end && (phase_q == end_ph);

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Step controller for the kinase chip pads: valve set, settle, N pump strokes.
// Define KINASE_PUMP_REV_EN to honour cmd_rev (reverse phase order).
module kinase_valve_sequencer
  import kinase_ctrl_pkg::*;
#(
  parameter int CTRL_A_W      = 13,
  parameter int CTRL_S_W      = 4,
  parameter int STROKE_W      = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int PHASE_CYCLES  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CTRL_A_W-1:0] cmd_ctrl_a,
  input  logic [CTRL_S_W-1:0] cmd_ctrl_s,
  input  logic [1:0]          cmd_pump_sel,
  input  logic [STROKE_W-1:0] cmd_strokes,
  input  logic                cmd_rev,
  input  logic                abort,
  output logic [CTRL_A_W-1:0] ctrl_a,
  output logic [CTRL_S_W-1:0] ctrl_s,
  output logic [2:0]          pump_a,
  output logic [1:0]          pump_b,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [STROKE_W-1:0] stroke_q, stroke_d;
  logic [STROKE_W-1:0] strokes_q, strokes_d;
  logic [CTRL_A_W-1:0] ctrl_a_q, ctrl_a_d;
  logic [CTRL_S_W-1:0] ctrl_s_q, ctrl_s_d;
  logic [1:0]          sel_q, sel_d;
  logic                rev_q, rev_d;
  logic                aborted_q, aborted_d;
  logic [2:0]          pump_a_q, pump_a_d;
  logic [1:0]          pump_b_q, pump_b_d;

  logic               gen_en, gen_rev, stroke_end, will_pump;
  logic [PHASE_W-1:0] phase_next;

  assign gen_en = (state_q == ST_PUMP);

`ifdef KINASE_PUMP_REV_EN
  assign gen_rev = rev_q;
`else
  logic unused_rev;
  assign gen_rev    = 1'b0;
  assign unused_rev = rev_q;
`endif

  kinase_pump_phase_gen #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (gen_en),
    .rev_i        (gen_rev),
    .phase_o      (phase_next),
    .stroke_end_o (stroke_end)
  );

  assign will_pump = (strokes_q != '0) && (sel_q != 2'b00);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    stroke_d  = stroke_q;
    strokes_d = strokes_q;
    ctrl_a_d  = ctrl_a_q;
    ctrl_s_d  = ctrl_s_q;
    sel_d     = sel_q;
    rev_d     = rev_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ctrl_a_d  = cmd_ctrl_a;
          ctrl_s_d  = cmd_ctrl_s;
          sel_d     = cmd_pump_sel;
          strokes_d = cmd_strokes;
          rev_d     = cmd_rev;
          settle_d  = '0;
          stroke_d  = '0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = will_pump ? ST_PUMP : ST_DONE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_PUMP: begin
        // Abort wins over a coincident natural finish so the flag is reported.
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (stroke_end) begin
          if (stroke_q + STROKE_W'(1) == strokes_q) begin
            state_d = ST_DONE;
          end else begin
            stroke_d = stroke_q + STROKE_W'(1);
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Pump pads are registered from the next state so they change with it.
    pump_a_d = PUMP_A_REST;
    pump_b_d = PUMP_B_REST;
    if (state_d == ST_PUMP) begin
      if (sel_q[0]) pump_a_d = PUMP_A_PHASE[phase_next];
      if (sel_q[1]) pump_b_d = PUMP_B_PHASE[phase_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      stroke_q  <= '0;
      strokes_q <= '0;
      ctrl_a_q  <= '1;
      ctrl_s_q  <= '1;
      sel_q     <= '0;
      rev_q     <= 1'b0;
      aborted_q <= 1'b0;
      pump_a_q  <= PUMP_A_REST;
      pump_b_q  <= PUMP_B_REST;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      stroke_q  <= stroke_d;
      strokes_q <= strokes_d;
      ctrl_a_q  <= ctrl_a_d;
      ctrl_s_q  <= ctrl_s_d;
      sel_q     <= sel_d;
      rev_q     <= rev_d;
      aborted_q <= aborted_d;
      pump_a_q  <= pump_a_d;
      pump_b_q  <= pump_b_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_PUMP);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;
  assign ctrl_a    = ctrl_a_q;
  assign ctrl_s    = ctrl_s_q;
  assign pump_a    = pump_a_q;
  assign pump_b    = pump_b_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer: two instances (PHASE_CYCLES 1 and 2) share
// stimulus; each cycle is checked against a per-step timeline model.
module tb_kinase_valve_sequencer;

  localparam int S = 2;
`ifdef KINASE_PUMP_REV_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif
  localparam logic [25:0] RST_VEC =
    {13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [1:0]  sel;
    int          strokes;
    bit          rev;
    int          abort_t;
    bit          busy_valid;
    int          exp_d0;
    int          exp_d1;
    bit          exp_ab0;
    bit          exp_ab1;
  } step_t;

  logic        clk, rst_n, cmd_valid, cmd_rev, abort;
  logic [12:0] cmd_ctrl_a;
  logic [3:0]  cmd_ctrl_s;
  logic [1:0]  cmd_pump_sel;
  logic [15:0] cmd_strokes;

  logic        cmd_ready_w [2];
  logic [12:0] ctrl_a_w    [2];
  logic [3:0]  ctrl_s_w    [2];
  logic [2:0]  pump_a_w    [2];
  logic [1:0]  pump_b_w    [2];
  logic        busy_w      [2];
  logic        done_w      [2];
  logic        aborted_w   [2];

  int errors = 0;
  int checks = 0;

  kinase_valve_sequencer #(
    .SETTLE_CYCLES (S),
    .PHASE_CYCLES  (1)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready_w[0]),
    .cmd_ctrl_a (cmd_ctrl_a), .cmd_ctrl_s (cmd_ctrl_s), .cmd_pump_sel (cmd_pump_sel),
    .cmd_strokes (cmd_strokes), .cmd_rev (cmd_rev), .abort (abort),
    .ctrl_a (ctrl_a_w[0]), .ctrl_s (ctrl_s_w[0]), .pump_a (pump_a_w[0]), .pump_b (pump_b_w[0]),
    .busy (busy_w[0]), .done (done_w[0]), .aborted (aborted_w[0])
  );

  kinase_valve_sequencer #(
    .SETTLE_CYCLES (S),
    .PHASE_CYCLES  (2)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready_w[1]),
    .cmd_ctrl_a (cmd_ctrl_a), .cmd_ctrl_s (cmd_ctrl_s), .cmd_pump_sel (cmd_pump_sel),
    .cmd_strokes (cmd_strokes), .cmd_rev (cmd_rev), .abort (abort),
    .ctrl_a (ctrl_a_w[1]), .ctrl_s (ctrl_s_w[1]), .pump_a (pump_a_w[1]), .pump_b (pump_b_w[1]),
    .busy (busy_w[1]), .done (done_w[1]), .aborted (aborted_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] observe(int i);
    return {ctrl_a_w[i], ctrl_s_w[i], pump_a_w[i], pump_b_w[i],
            busy_w[i], done_w[i], aborted_w[i], cmd_ready_w[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---- reference model: timeline of one step, t = cycles after the accept edge
  function automatic int phase_cycles(int inst);
    return (inst == 0) ? 1 : 2;
  endfunction

  function automatic int pump_len(int inst, step_t s);
    return (s.strokes != 0 && s.sel != 2'b00) ? s.strokes * 6 * phase_cycles(inst) : 0;
  endfunction

  function automatic bit abort_hits(int inst, step_t s);
    return (s.abort_t >= 1) && (s.abort_t <= S + pump_len(inst, s));
  endfunction

  function automatic int done_time(int inst, step_t s);
    return abort_hits(inst, s) ? s.abort_t + 1 : S + pump_len(inst, s) + 1;
  endfunction

  function automatic logic [2:0] pa_lut(int ph);
    case (ph)
      0:       return 3'b011;
      1:       return 3'b001;
      2:       return 3'b101;
      3:       return 3'b100;
      4:       return 3'b110;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [25:0] expect_at(int inst, int t, step_t s);
    logic [2:0] pa = 3'b111;
    logic [1:0] pb = 2'b11;
    logic bz = 1'b0, dn = 1'b0, ab = 1'b0, rdy = 1'b0;
    int dt = done_time(inst, s);
    int k, ph;
    if (t < dt) begin
      bz = 1'b1;
      if (t > S) begin
        k  = t - S - 1;
        ph = (k / phase_cycles(inst)) % 6;
        if (s.rev && REV_EN) ph = 5 - ph;
        if (s.sel[0]) pa = pa_lut(ph);
        if (s.sel[1]) pb = (ph < 3) ? 2'b01 : 2'b10;
      end
    end else if (t == dt) begin
      dn = 1'b1;
      ab = abort_hits(inst, s);
    end else begin
      rdy = 1'b1;
    end
    return {s.ctrl_a, s.ctrl_s, pa, pb, bz, dn, ab, rdy};
  endfunction

  task automatic present(input step_t s);
    cmd_valid    = 1'b1;
    cmd_ctrl_a   = s.ctrl_a;
    cmd_ctrl_s   = s.ctrl_s;
    cmd_pump_sel = s.sel;
    cmd_strokes  = 16'(s.strokes);
    cmd_rev      = s.rev;
  endtask

  // Called at a negedge with both instances idle.
  task automatic run_step(input step_t s, input string tag, input bit chk_done);
    int  dt0, dt1, tend;
    int  seen_t [2];
    bit  seen_ab [2];
    dt0  = done_time(0, s);
    dt1  = done_time(1, s);
    tend = ((dt0 > dt1) ? dt0 : dt1) + 1;
    seen_t  = '{0, 0};
    seen_ab = '{1'b0, 1'b0};
    present(s);
    for (int t = 1; t <= tend; t++) begin
      @(posedge clk);
      #1;
      cmd_valid = s.busy_valid && (t <= 2);
      if (s.busy_valid) begin
        cmd_ctrl_a  = ~s.ctrl_a;
        cmd_ctrl_s  = ~s.ctrl_s;
        cmd_strokes = 16'(s.strokes + 7);
      end
      abort = (t == s.abort_t);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("%s/i%0d/t%0d", tag, i, t), 32'(observe(i)), 32'(expect_at(i, t, s)));
        if (done_w[i] === 1'b1 && seen_t[i] == 0) begin
          seen_t[i]  = t;
          seen_ab[i] = aborted_w[i];
        end
      end
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
    if (chk_done) begin
      check({tag, "/done_t0"}, 32'(seen_t[0]), 32'(s.exp_d0));
      check({tag, "/done_t1"}, 32'(seen_t[1]), 32'(s.exp_d1));
      check({tag, "/ab0"}, 32'(seen_ab[0]), 32'(s.exp_ab0));
      check({tag, "/ab1"}, 32'(seen_ab[1]), 32'(s.exp_ab1));
    end
    $display("step %s: ctrl_a=%h sel=%b strokes=%0d rev=%0b abort_t=%0d done_t=%0d/%0d",
             tag, s.ctrl_a, s.sel, s.strokes, s.rev, s.abort_t, seen_t[0], seen_t[1]);
  endtask

  step_t tbl [9];
  step_t s;

  initial begin
    // ctrl_a, ctrl_s, sel, strokes, rev, abort_t, busy_valid, done0, done1, ab0, ab1
    tbl[0] = '{13'h0005, 4'h3, 2'b01,   2, 1'b0, 0, 1'b0, 15, 27, 1'b0, 1'b0};
    tbl[1] = '{13'h1ABC, 4'hA, 2'b11,   0, 1'b0, 0, 1'b0,  3,  3, 1'b0, 1'b0};
    tbl[2] = '{13'h0F0F, 4'h5, 2'b11, 100, 1'b0, 7, 1'b0,  8,  8, 1'b1, 1'b1};
    tbl[3] = '{13'h1234, 4'hC, 2'b11,   1, 1'b0, 0, 1'b1,  9, 15, 1'b0, 1'b0};
    tbl[4] = '{13'h0777, 4'h6, 2'b01,   1, 1'b1, 0, 1'b0,  9, 15, 1'b0, 1'b0};
    tbl[5] = '{13'h1FFE, 4'h0, 2'b00,   5, 1'b0, 0, 1'b0,  3,  3, 1'b0, 1'b0};
    tbl[6] = '{13'h0001, 4'h1, 2'b10,   3, 1'b0, 1, 1'b0,  2,  2, 1'b1, 1'b1};
    tbl[7] = '{13'h0002, 4'h2, 2'b10,   1, 1'b0, 8, 1'b0,  9,  9, 1'b1, 1'b1};
    tbl[8] = '{13'h0003, 4'h3, 2'b01,   1, 1'b0, 9, 1'b0,  9, 10, 1'b0, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_rev = 1'b0;
    cmd_ctrl_a = '0; cmd_ctrl_s = '0; cmd_pump_sel = '0; cmd_strokes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("reset/i%0d", i), 32'(observe(i)), 32'(RST_VEC));
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("post_reset/i%0d", i), 32'(observe(i)), 32'(RST_VEC));

    for (int n = 0; n < 9; n++) run_step(tbl[n], $sformatf("dir%0d", n), 1'b1);

    // Reset in the middle of a pumping step: pads to rest, no done afterwards.
    s = '{13'h0AAA, 4'h9, 2'b11, 2, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    present(s);
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        check($sformatf("midrst_pre/i%0d/t%0d", i, t), 32'(observe(i)), 32'(expect_at(i, t, s)));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        check($sformatf("midrst/i%0d/c%0d", i, c), 32'(observe(i)), 32'(RST_VEC));
    end
    $display("step midreset: reset asserted at t=5");

    for (int n = 0; n < 25; n++) begin
      s.ctrl_a     = 13'($urandom);
      s.ctrl_s     = 4'($urandom);
      s.sel        = 2'($urandom);
      s.strokes    = $urandom_range(0, 3);
      s.rev        = 1'($urandom);
      s.busy_valid = 1'($urandom);
      s.abort_t    = 0;
      if ($urandom_range(0, 2) == 0) s.abort_t = $urandom_range(1, done_time(0, s) + 2);
      s.exp_d0 = 0; s.exp_d1 = 0; s.exp_ab0 = 1'b0; s.exp_ab1 = 1'b0;
      run_step(s, $sformatf("rnd%0d", n), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
